// File: rtl/minsort_ctrl.sv
// minsort_ctrl
//   Sequencer for an in-place ascending selection sort over the first Len
//   words of a single-port synchronous RAM. For each outer index i it scans
//   i+1..Len-1, steering an external min-address register (Load_Addr /
//   Mux_Addr -> Min_Addr), and at the end of the pass swaps Mem[i] with
//   Mem[Min_Addr] when they differ.
//
// Ports
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   Start, Len          host request (sampled in IDLE) and element count
//   Busy, Done          high outside IDLE / one-cycle completion pulse
//   Mem_Addr            RAM address
//   Mem_Rd_En           RAM read strobe, Mem_Rd_Data valid the next cycle
//   Mem_Rd_Data         RAM read data
//   Mem_Wr_En           RAM write strobe, Mem_Wr_Data written at the same edge
//   Mem_Wr_Data         RAM write data
//   Load_Addr, Mux_Addr load strobe / value for the min-address register
//   Min_Addr            min-address register output
module minsort_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [ADDR_W:0]   Len,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Rd_En,
    input  logic [DATA_W-1:0] Mem_Rd_Data,
    output logic              Mem_Wr_En,
    output logic [DATA_W-1:0] Mem_Wr_Data,
    output logic              Load_Addr,
    output logic [ADDR_W-1:0] Mux_Addr,
    input  logic [ADDR_W-1:0] Min_Addr
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_I,
        S_CAP_I,
        S_RD_J,
        S_CMP_J,
        S_SWAP_CHK,
        S_SWAP_W1,
        S_SWAP_W2,
        S_NEXT_I,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] TWO     = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    // i and j carry one extra bit so Len_q = 2**ADDR_W is representable
    // and the last j (2**ADDR_W-1) never wraps.
    logic [ADDR_W:0]   i;
    logic [ADDR_W:0]   j;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] min_val;
    logic [DATA_W-1:0] i_val;

    logic [ADDR_W:0]   len_clamp;
    logic [ADDR_W:0]   last_j;
    logic [ADDR_W:0]   last_i;
    logic              rd_less;

    assign len_clamp = (Len > LEN_MAX) ? LEN_MAX : Len;
    assign last_j    = len_q - ONE;
    assign last_i    = len_q - TWO;
    // Strict compare: equal values keep the earlier minimum.
    assign rd_less   = (Mem_Rd_Data < min_val);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= S_IDLE;
            i       <= '0;
            j       <= '0;
            len_q   <= '0;
            min_val <= '0;
            i_val   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        len_q <= len_clamp;
                        i     <= '0;
                        state <= (len_clamp < TWO) ? S_DONE : S_LOAD_I;
                    end
                end
                S_LOAD_I: begin
                    j     <= i + ONE;
                    state <= S_CAP_I;
                end
                S_CAP_I: begin
                    min_val <= Mem_Rd_Data;
                    i_val   <= Mem_Rd_Data;
                    state   <= S_RD_J;
                end
                S_RD_J: begin
                    state <= S_CMP_J;
                end
                S_CMP_J: begin
                    if (rd_less) begin
                        min_val <= Mem_Rd_Data;
                    end
                    if (j == last_j) begin
                        state <= S_SWAP_CHK;
                    end else begin
                        j     <= j + ONE;
                        state <= S_RD_J;
                    end
                end
                S_SWAP_CHK: begin
                    // Min_Addr already reflects a load issued in the final CMP_J.
                    state <= ({1'b0, Min_Addr} == i) ? S_NEXT_I : S_SWAP_W1;
                end
                S_SWAP_W1: begin
                    state <= S_SWAP_W2;
                end
                S_SWAP_W2: begin
                    state <= S_NEXT_I;
                end
                S_NEXT_I: begin
                    if (i == last_i) begin
                        state <= S_DONE;
                    end else begin
                        i     <= i + ONE;
                        state <= S_LOAD_I;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from the registered state; CMP_J additionally looks at
    // the read data to decide whether the min-address register loads.
    always_comb begin
        Busy        = (state != S_IDLE);
        Done        = (state == S_DONE);
        Mem_Addr    = '0;
        Mem_Rd_En   = 1'b0;
        Mem_Wr_En   = 1'b0;
        Mem_Wr_Data = '0;
        Load_Addr   = 1'b0;
        Mux_Addr    = '0;
        case (state)
            S_LOAD_I: begin
                Mem_Rd_En = 1'b1;
                Mem_Addr  = i[ADDR_W-1:0];
                Load_Addr = 1'b1;
                Mux_Addr  = i[ADDR_W-1:0];
            end
            S_RD_J: begin
                Mem_Rd_En = 1'b1;
                Mem_Addr  = j[ADDR_W-1:0];
            end
            S_CMP_J: begin
                if (rd_less) begin
                    Load_Addr = 1'b1;
                    Mux_Addr  = j[ADDR_W-1:0];
                end
            end
            S_SWAP_W1: begin
                Mem_Wr_En   = 1'b1;
                Mem_Addr    = Min_Addr;
                Mem_Wr_Data = i_val;
            end
            S_SWAP_W2: begin
                Mem_Wr_En   = 1'b1;
                Mem_Addr    = i[ADDR_W-1:0];
                Mem_Wr_Data = min_val;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_minsort_ctrl.sv
module tb_minsort_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          Clk;
    logic          Rst_n;
    logic          Start;
    logic [AW:0]   Len;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] Mem_Addr;
    logic          Mem_Rd_En;
    logic [DW-1:0] Mem_Rd_Data;
    logic          Mem_Wr_En;
    logic [DW-1:0] Mem_Wr_Data;
    logic          Load_Addr;
    logic [AW-1:0] Mux_Addr;
    logic [AW-1:0] Min_Addr;

    // RAM model with a bench-side preload port
    logic [DW-1:0] mem [256];
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_wdata;

    int checks   = 0;
    int failures = 0;

    // cumulative activity counters, sampled on the falling edge
    int            busy_cyc  = 0;
    int            done_cnt  = 0;
    int            rd_cyc    = 0;
    int            wr_cyc    = 0;
    int            cmp_loads = 0;
    logic [AW-1:0] last_cmp_mux = '0;

    // results of the last run
    int r_busy, r_done, r_rd, r_wr, r_loads;
    int bad;

    minsort_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Len(Len),
        .Busy(Busy), .Done(Done), .Mem_Addr(Mem_Addr), .Mem_Rd_En(Mem_Rd_En),
        .Mem_Rd_Data(Mem_Rd_Data), .Mem_Wr_En(Mem_Wr_En), .Mem_Wr_Data(Mem_Wr_Data),
        .Load_Addr(Load_Addr), .Mux_Addr(Mux_Addr), .Min_Addr(Min_Addr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (Mem_Wr_En) mem[Mem_Addr] <= Mem_Wr_Data;
        if (Mem_Rd_En) Mem_Rd_Data <= mem[Mem_Addr];
    end

    // min-address register model
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) Min_Addr <= '0;
        else if (Load_Addr) Min_Addr <= Mux_Addr;
    end

    always @(negedge Clk) begin
        if (Busy) busy_cyc <= busy_cyc + 1;
        if (Done) done_cnt <= done_cnt + 1;
        if (Mem_Rd_En) rd_cyc <= rd_cyc + 1;
        if (Mem_Wr_En) wr_cyc <= wr_cyc + 1;
        if (Load_Addr && !Mem_Rd_En) begin
            cmp_loads    <= cmp_loads + 1;
            last_cmp_mux <= Mux_Addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic write_word(input int a, input int v);
        tb_we    = 1'b1;
        tb_addr  = AW'(a);
        tb_wdata = DW'(v);
        tick();
        tb_we    = 1'b0;
    endtask

    task automatic run_sort(input string tag, input int len, input bit hold, input int budget);
        int b0, d0, rd0, w0, l0, n;
        b0 = busy_cyc; d0 = done_cnt; rd0 = rd_cyc; w0 = wr_cyc; l0 = cmp_loads;
        Start = 1'b1;
        Len   = (AW+1)'(len);
        tick();
        if (!hold) Start = 1'b0;
        n = 0;
        while (!Done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_no_timeout"}, (n < budget), 1);
        tick();
        Start = 1'b0;
        tick();
        tick();
        r_busy  = busy_cyc - b0;
        r_done  = done_cnt - d0;
        r_rd    = rd_cyc - rd0;
        r_wr    = wr_cyc - w0;
        r_loads = cmp_loads - l0;
    endtask

    function automatic logic [63:0] out_vec();
        return {Busy, Done, Mem_Addr, Mem_Rd_En, Mem_Wr_En, Mem_Wr_Data, Load_Addr, Mux_Addr};
    endfunction

    initial begin
        Rst_n    = 1'b0;
        Start    = 1'b0;
        Len      = '0;
        tb_we    = 1'b0;
        tb_addr  = '0;
        tb_wdata = '0;
        tick();
        tick();
        chk("por_outputs_zero", out_vec(), 0);
        Rst_n = 1'b1;
        tick();

        // reset in the middle of a scan
        write_word(0, 4); write_word(1, 1); write_word(2, 3); write_word(3, 2);
        Start = 1'b1;
        Len   = 9'd4;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        chk("midscan_busy", Busy, 1);
        #2 Rst_n = 1'b0;
        #1;
        chk("async_reset_outputs_zero", out_vec(), 0);
        tick();
        chk("reset_held_idle", Busy, 0);
        Rst_n = 1'b1;
        tick();
        chk("after_reset_idle", out_vec(), 0);

        // [4,1,3,2] -> [1,2,3,4]
        write_word(0, 4); write_word(1, 1); write_word(2, 3); write_word(3, 2);
        run_sort("t2", 4, 1'b0, 200);
        chk("t2_mem0", mem[0], 1);
        chk("t2_mem1", mem[1], 2);
        chk("t2_mem2", mem[2], 3);
        chk("t2_mem3", mem[3], 4);
        chk("t2_done_pulses", r_done, 1);
        chk("t2_write_cycles", r_wr, 4);
        chk("t2_read_cycles", r_rd, 9);
        chk("t2_busy_cycles", r_busy, 29);

        // already sorted [1,2,3]
        write_word(0, 1); write_word(1, 2); write_word(2, 3);
        run_sort("t3", 3, 1'b0, 200);
        chk("t3_write_cycles", r_wr, 0);
        chk("t3_read_cycles", r_rd, 5);
        chk("t3_busy_cycles", r_busy, 15);
        chk("t3_mem2", mem[2], 3);

        // duplicates [2,2,1] -> [1,2,2], only j=2 loads the min register
        write_word(0, 2); write_word(1, 2); write_word(2, 1);
        run_sort("t4", 3, 1'b0, 200);
        chk("t4_cmp_loads", r_loads, 1);
        chk("t4_last_cmp_mux", last_cmp_mux, 2);
        chk("t4_write_cycles", r_wr, 2);
        chk("t4_busy_cycles", r_busy, 17);
        chk("t4_mem0", mem[0], 1);
        chk("t4_mem1", mem[1], 2);
        chk("t4_mem2", mem[2], 2);

        // degenerate lengths, Start held through Busy for Len=1
        run_sort("t5a", 0, 1'b0, 20);
        chk("t5a_busy_cycles", r_busy, 1);
        chk("t5a_rd_wr", r_rd + r_wr, 0);
        chk("t5a_done_pulses", r_done, 1);
        run_sort("t5b", 1, 1'b1, 20);
        chk("t5b_busy_cycles", r_busy, 1);
        chk("t5b_rd_wr", r_rd + r_wr, 0);
        chk("t5b_done_pulses", r_done, 1);
        chk("t5b_idle_after", Busy, 0);

        // full-depth reverse data
        for (int k = 0; k < 256; k++) write_word(k, 255 - k);
        run_sort("t6", 256, 1'b0, 70000);
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== DW'(k)) bad++;
        chk("t6_unsorted_words", bad, 0);
        chk("t6_mem255", mem[255], 255);
        chk("t6_write_cycles", r_wr, 256);
        chk("t6_read_cycles", r_rd, 32895);
        chk("t6_busy_cycles", r_busy, 66557);
        chk("t6_done_pulses", r_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
